// File: rtl/tt_pkg.sv
// Shared types, sizes and helper functions for the truth-table sweeper.
// Widths are fixed for a 4-variable function (16 input vectors).
package tt_pkg;

   localparam int unsigned N_VARS = 4;
   localparam int unsigned N_VEC  = 16;
   localparam int unsigned RES_W  = N_VEC;
   localparam int unsigned CNT_W  = 5;

   typedef enum logic [1:0] {
      StIdle,
      StSweep,
      StCheck,
      StDone
   } tt_state_e;

   function automatic logic [CNT_W-1:0] popcount(input logic [RES_W-1:0] v);
      logic [CNT_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < int'(RES_W); i++) begin
         cnt = cnt + CNT_W'(v[i]);
      end
      return cnt;
   endfunction

   // Index of the lowest set bit, 0 when v is all zero.
   function automatic logic [N_VARS-1:0] lowest_set(input logic [RES_W-1:0] v);
      logic [N_VARS-1:0] idx;
      idx = '0;
      for (int i = int'(RES_W) - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = N_VARS'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/pos_eval.sv
// Product-of-sums evaluator: every mask bit contributes one maxterm that is
// zero only for its own input vector, so f = ~mask[vec].
module pos_eval
   import tt_pkg::*;
(
   input  logic [N_VARS-1:0] vec,
   input  logic [N_VEC-1:0]  mask,
   output logic              s
);

   always_comb begin
      s = 1'b1;
      for (int i = 0; i < int'(N_VEC); i++) begin
         // Unmasked terms are forced to 1 and drop out of the product.
         s = s & (~mask[i] | (vec != N_VARS'(i)));
      end
   end

endmodule

// File: rtl/truth_table_sweeper.sv
// Steps a 4-input vector through all 16 values, captures the evaluated function
// into a truth table and compares it against an expected table.
module truth_table_sweeper
   import tt_pkg::*;
#(
   parameter int unsigned SETTLE = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [N_VEC-1:0]  maxterm_mask,
   input  logic [RES_W-1:0]  expected,
   output logic [N_VARS-1:0] vec,
   output logic              busy,
   output logic              done,
   output logic [RES_W-1:0]  result,
   output logic [CNT_W-1:0]  mismatch_count,
   output logic              pass,
   output logic [N_VARS-1:0] first_fail
);

   localparam logic [1:0]        SettleCnt = 2'(SETTLE);
   localparam logic [N_VARS-1:0] LastIdx   = N_VARS'(N_VEC - 1);

   tt_state_e         state_q, state_d;
   logic [N_VARS-1:0] idx_q, idx_d;
   logic [1:0]        wait_q, wait_d;
   logic [N_VEC-1:0]  mask_q, mask_d;
   logic [RES_W-1:0]  exp_q, exp_d;
   logic [RES_W-1:0]  result_q, result_d;
   logic [CNT_W-1:0]  mm_q, mm_d;
   logic              pass_q, pass_d;
   logic [N_VARS-1:0] ff_q, ff_d;
   logic              f;

   pos_eval u_pos_eval (
      .vec  (idx_q),
      .mask (mask_q),
      .s    (f)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         wait_q   <= '0;
         mask_q   <= '0;
         exp_q    <= '0;
         result_q <= '0;
         mm_q     <= '0;
         pass_q   <= 1'b0;
         ff_q     <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         wait_q   <= wait_d;
         mask_q   <= mask_d;
         exp_q    <= exp_d;
         result_q <= result_d;
         mm_q     <= mm_d;
         pass_q   <= pass_d;
         ff_q     <= ff_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      wait_d   = wait_q;
      mask_d   = mask_q;
      exp_d    = exp_q;
      result_d = result_q;
      mm_d     = mm_q;
      pass_d   = pass_q;
      ff_d     = ff_q;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d  = StSweep;
               mask_d   = maxterm_mask;
               exp_d    = expected;
               result_d = '0;
               mm_d     = '0;
               pass_d   = 1'b0;
               ff_d     = '0;
               idx_d    = '0;
               wait_d   = '0;
            end
         end
         StSweep: begin
            if (wait_q == SettleCnt) begin
               result_d[idx_q] = f;
               wait_d          = '0;
               // idx parks at the last vector instead of wrapping.
               if (idx_q == LastIdx) begin
                  state_d = StCheck;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         StCheck: begin
            mm_d    = popcount(result_q ^ exp_q);
            pass_d  = (result_q == exp_q);
            ff_d    = lowest_set(result_q ^ exp_q);
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign vec            = idx_q;
   assign busy           = (state_q == StSweep) || (state_q == StCheck);
   assign done           = (state_q == StDone);
   assign result         = result_q;
   assign mismatch_count = mm_q;
   assign pass           = pass_q;
   assign first_fail     = ff_q;

endmodule
